// File: rtl/mips_dbg_pkg.sv
// Byte protocol constants and loader state encodings shared with the debug unit.
package mips_dbg_pkg;

  // UART command/reply bytes
  localparam logic [7:0] DBG_CMD_LOAD = 8'h6C;  // 'l'
  localparam logic [7:0] DBG_ACK      = 8'h6B;  // 'k'
  localparam logic [7:0] DBG_NAK      = 8'h65;  // 'e'

  // Program loader state encoding
  localparam int unsigned PL_STATE_W = 3;
  localparam logic [PL_STATE_W-1:0] PL_IDLE     = 3'd0;
  localparam logic [PL_STATE_W-1:0] PL_LEN_LO   = 3'd1;
  localparam logic [PL_STATE_W-1:0] PL_LEN_HI   = 3'd2;
  localparam logic [PL_STATE_W-1:0] PL_DATA     = 3'd3;
  localparam logic [PL_STATE_W-1:0] PL_WRITE    = 3'd4;
  localparam logic [PL_STATE_W-1:0] PL_ACK_SEND = 3'd5;
  localparam logic [PL_STATE_W-1:0] PL_NAK_SEND = 3'd6;
  localparam logic [PL_STATE_W-1:0] PL_TX_WAIT  = 3'd7;

endpackage

// File: rtl/byte_assembler.sv
// Packs four received bytes into a 32-bit word, little endian (first byte -> [7:0]).
module byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  cnt_o,
  output logic        valid_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        valid_q;

  // Shift bytes in from the top so the first byte ends up in the low lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (shift_i) begin
      word_q  <= {byte_i, word_q[31:8]};
      cnt_q   <= cnt_q + 2'd1;
      valid_q <= (cnt_q == 2'd3);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign word_o  = word_q;
  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/program_loader.sv
// UART program loader: receives a length-prefixed image, writes it to instruction
// memory one word at a time, replies ACK/NAK and then releases the datapath.
module program_loader
  import mips_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  CMD_LOAD = DBG_CMD_LOAD,
  parameter logic [7:0]  ACK      = DBG_ACK,
  parameter logic [7:0]  NAK      = DBG_NAK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_bus,
  input  logic              tx_done,
  output logic              tx_write,
  output logic [7:0]        tx_bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dp_reset,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [15:0]          DEPTH16  = 16'(DEPTH);

  logic [PL_STATE_W-1:0] state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [7:0]            tx_bus_q, tx_bus_d;
  logic                  dp_reset_q, dp_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic                  timeout;
  logic [15:0]           len_full;
  logic                  asm_clr;
  logic                  asm_shift;
  logic [31:0]           asm_word;
  logic [1:0]            asm_cnt;
  logic                  asm_valid;

  byte_assembler u_asm (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (asm_clr),
    .shift_i (asm_shift),
    .byte_i  (rx_bus),
    .word_o  (asm_word),
    .cnt_o   (asm_cnt),
    .valid_o (asm_valid)
  );

  assign len_full = {rx_bus, n_q[7:0]};

  // Next-state logic: FSM, length/word counters, inter-byte timeout
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    idle_cnt_d   = '0;
    tx_bus_d     = tx_bus_q;
    dp_reset_d   = dp_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    asm_clr      = 1'b0;
    asm_shift    = 1'b0;
    timeout      = 1'b0;

    // Any received byte restarts the silence window; it only runs mid-transfer
    if (state_q inside {PL_LEN_LO, PL_LEN_HI, PL_DATA}) begin
      if (rx_rdy) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TMO_LAST) begin
        timeout    = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    case (state_q)
      PL_IDLE: begin
        if (rx_rdy && (rx_bus == CMD_LOAD)) begin
          state_d      = PL_LEN_LO;
          dp_reset_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          n_d          = '0;
          word_cnt_d   = '0;
          asm_clr      = 1'b1;
        end
      end
      PL_LEN_LO: begin
        if (rx_rdy) begin
          n_d     = {8'h00, rx_bus};
          state_d = PL_LEN_HI;
        end else if (timeout) begin
          tx_bus_d = NAK;
          state_d  = PL_NAK_SEND;
        end
      end
      PL_LEN_HI: begin
        if (rx_rdy) begin
          n_d = len_full;
          if (len_full > DEPTH16) begin
            tx_bus_d = NAK;
            state_d  = PL_NAK_SEND;
          end else if (len_full == 16'd0) begin
            tx_bus_d = ACK;
            state_d  = PL_ACK_SEND;
          end else begin
            word_cnt_d = '0;
            state_d    = PL_DATA;
          end
        end else if (timeout) begin
          tx_bus_d = NAK;
          state_d  = PL_NAK_SEND;
        end
      end
      PL_DATA: begin
        if (rx_rdy) begin
          asm_shift = 1'b1;
          if (asm_cnt == 2'd3) state_d = PL_WRITE;
        end else if (timeout) begin
          asm_clr  = 1'b1;
          tx_bus_d = NAK;
          state_d  = PL_NAK_SEND;
        end
      end
      PL_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        if (word_cnt_d == n_q) begin
          tx_bus_d = ACK;
          state_d  = PL_ACK_SEND;
        end else begin
          state_d = PL_DATA;
        end
      end
      PL_ACK_SEND, PL_NAK_SEND: begin
        state_d = PL_TX_WAIT;
      end
      PL_TX_WAIT: begin
        if (tx_done) begin
          if (tx_bus_q == ACK) begin
            dp_reset_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            load_error_d = 1'b1;
          end
          state_d = PL_IDLE;
        end
      end
      default: state_d = PL_IDLE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PL_IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      tx_bus_q     <= '0;
      dp_reset_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      tx_bus_q     <= tx_bus_d;
      dp_reset_q   <= dp_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // The assembler's valid pulse coincides exactly with the WRITE state
  assign imem_we    = asm_valid;
  assign imem_addr  = word_cnt_q[ADDR_W-1:0];
  assign imem_wdata = asm_word;
  assign tx_write   = (state_q == PL_ACK_SEND) || (state_q == PL_NAK_SEND);
  assign tx_bus     = tx_bus_q;
  assign dp_reset   = dp_reset_q;
  assign busy       = (state_q != PL_IDLE);
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a shortened inter-byte timeout.
module tb_program_loader;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_bus = '0;
  logic        tx_done = 1'b0;
  logic        tx_write;
  logic [7:0]  tx_bus;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dp_reset;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int n_assert = 0;
  int n_fail   = 0;

  // write/tx log and pulse-width watch
  int          wr_n = 0;
  int          tx_n = 0;
  int          pulse_err = 0;
  logic [7:0]  wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  logic        we_prev = 1'b0;
  logic        txw_prev = 1'b0;

  program_loader #(
    .ADDR_W  (8),
    .DEPTH   (256),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_rdy     (rx_rdy),
    .rx_bus     (rx_bus),
    .tx_done    (tx_done),
    .tx_write   (tx_write),
    .tx_bus     (tx_bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dp_reset   (dp_reset),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 16) begin
        wr_addr_log[wr_n] = imem_addr;
        wr_data_log[wr_n] = imem_wdata;
      end
      wr_n++;
    end
    if (tx_write) tx_n++;
    if (imem_we && we_prev) pulse_err++;
    if (tx_write && txw_prev) pulse_err++;
    we_prev  = imem_we;
    txw_prev = tx_write;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_rdy = 1'b1;
    rx_bus = b;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic wait_tx(input int limit, output logic [7:0] b, output int cyc);
    b   = '0;
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (tx_write) begin
        b   = tx_bus;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_tx_done;
    repeat (2) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  logic [7:0] b;
  int         cyc;
  int         wr0;
  int         tx0;

  initial begin
    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_dp_reset", dp_reset, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_txw", tx_write, 0);
    chk("rst_txbus", tx_bus, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    #11 reset_n = 1'b1;

    // two-word load
    send_byte(8'h6C); send_byte(8'h02); send_byte(8'h00);
    chk("t1_busy", busy, 1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    chk("t1_we0", imem_we, 1);
    chk("t1_addr0", imem_addr, 0);
    chk("t1_data0", imem_wdata, 32'h12345678);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    @(negedge clk);
    chk("t1_we1", imem_we, 1);
    chk("t1_addr1", imem_addr, 1);
    chk("t1_data1", imem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_txw", tx_write, 1);
    chk("t1_ack", tx_bus, 8'h6B);
    chk("t1_dp_hold", dp_reset, 1);
    pulse_tx_done;
    @(negedge clk);
    chk("t1_dp_rel", dp_reset, 0);
    chk("t1_done", load_done, 1);
    chk("t1_err", load_error, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nwr", wr_n, 2);
    chk("t1_ntx", tx_n, 1);
    chk("t1_log0", wr_data_log[0], 32'h12345678);
    chk("t1_log1", {24'h0, wr_addr_log[1]}, 1);

    // zero-length load; a byte arriving while waiting for tx_done is dropped
    wr0 = wr_n;
    send_byte(8'h6C); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk("t2_txw", tx_write, 1);
    chk("t2_ack", tx_bus, 8'h6B);
    send_byte(8'h6C);
    pulse_tx_done;
    @(negedge clk);
    chk("t2_dp_rel", dp_reset, 0);
    chk("t2_done", load_done, 1);
    @(negedge clk);
    chk("t2_idle", busy, 0);
    chk("t2_nwr", wr_n, wr0);

    // N = 257 exceeds depth
    wr0 = wr_n;
    send_byte(8'h6C); send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    chk("t3_txw", tx_write, 1);
    chk("t3_nak", tx_bus, 8'h65);
    chk("t3_done_clr", load_done, 0);
    pulse_tx_done;
    @(negedge clk);
    chk("t3_err", load_error, 1);
    chk("t3_dp_hold", dp_reset, 1);
    chk("t3_idle", busy, 0);
    chk("t3_nwr", wr_n, wr0);

    // silence mid-word: NAK exactly TIMEOUT idle cycles after the last byte
    wr0 = wr_n;
    send_byte(8'h6C); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    wait_tx(200, b, cyc);
    chk("t4_tmo_cyc", cyc, TMO + 1);
    chk("t4_nak", b, 8'h65);
    chk("t4_wdata_clr", imem_wdata, 0);
    pulse_tx_done;
    @(negedge clk);
    chk("t4_err", load_error, 1);
    chk("t4_idle", busy, 0);
    chk("t4_nwr", wr_n, wr0);

    // reset mid-transfer, then a load whose data contains the command byte
    send_byte(8'h6C); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_dp", dp_reset, 1);
    chk("t5_wdata", imem_wdata, 0);
    chk("t5_addr", imem_addr, 0);
    chk("t5_txbus", tx_bus, 0);
    chk("t5_err", load_error, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr0 = wr_n;
    send_byte(8'h6C); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h6C); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    @(negedge clk);
    chk("t5_we", imem_we, 1);
    chk("t5_data", imem_wdata, 32'h1122336C);
    wait_tx(10, b, cyc);
    chk("t5_ack", b, 8'h6B);
    pulse_tx_done;
    @(negedge clk);
    chk("t5_done", load_done, 1);
    chk("t5_dp_rel", dp_reset, 0);
    chk("t5_nwr", wr_n, wr0 + 1);

    // debug traffic is ignored
    wr0 = wr_n;
    tx0 = tx_n;
    send_byte(8'h70);
    @(negedge clk);
    chk("t6_busy_a", busy, 0);
    send_byte(8'h63);
    @(negedge clk);
    chk("t6_busy_b", busy, 0);
    repeat (5) @(negedge clk);
    chk("t6_dp", dp_reset, 0);
    chk("t6_done", load_done, 1);
    chk("t6_nwr", wr_n, wr0);
    chk("t6_ntx", tx_n, tx0);

    chk("pulse_width", pulse_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
